// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into 32-bit machine words and
// queues them, each with its own word address, in a 2-entry output FIFO.
//
// Parameters: ADDR_W (address width), BASE_ADDR (first address, value after
//             reset/clear)
// Ports:
//   clk_i, rst_i (async, active-high), clear_i (sync flush)
//   in_valid_i/in_ready_o      request handshake
//   kind_i, rd_i, rs1_i, rs2_i, funct3_i, funct7b5_i, imm_i   decoded fields
//   out_valid_o/out_ready_i    FIFO head handshake
//   instr_o, addr_o            FIFO head word and its address
//   count_o                    words enqueued since reset/clear, saturating
//   err_o                      sticky range-error flag
// Build option: ENCODER_RANGE_CHECK_EN enables immediate range checking;
// without it out-of-range fields are truncated and err_o is tied to 0.
module instr_encoder #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        kind_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic              funct7b5_i,
  input  logic [31:0]       imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [15:0]       count_o,
  output logic              err_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [3:0] K_R      = 4'd0;
  localparam logic [3:0] K_IARITH = 4'd1;
  localparam logic [3:0] K_LOAD   = 4'd2;
  localparam logic [3:0] K_STORE  = 4'd3;
  localparam logic [3:0] K_BRANCH = 4'd4;
  localparam logic [3:0] K_JAL    = 4'd5;
  localparam logic [3:0] K_JALR   = 4'd6;
  localparam logic [3:0] K_LUI    = 4'd7;
  localparam logic [3:0] K_AUIPC  = 4'd8;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   instr;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t            head_q, tail_q, head_n, tail_n, new_e;
  logic              tail_v_q, tail_v_n, head_v_n, ready_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [CNT_W-1:0]  cnt_n;
  logic [XLEN-1:0]   word_c;
  logic [11:0]       imm_ia_c;
  logic              is_shift_c, range_err_c, push_c, enq_c, pop_c;

  assign instr_o = head_q.instr;
  assign addr_o  = head_q.addr;

  assign push_c = in_valid_i && in_ready_o && !clear_i;
  assign enq_c  = push_c && !range_err_c;
  assign pop_c  = out_valid_o && out_ready_i && !clear_i;

  // Field packing: one case arm per instruction format
  always_comb begin
    word_c     = NOP_WORD;
    is_shift_c = (funct3_i == 3'b001) || (funct3_i == 3'b101);
    imm_ia_c   = is_shift_c ? {1'b0, funct7b5_i, 5'b0, imm_i[4:0]} : imm_i[11:0];
    case (kind_i)
      K_R:      word_c = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, 7'b0110011};
      K_IARITH: word_c = {imm_ia_c, rs1_i, funct3_i, rd_i, 7'b0010011};
      K_LOAD:   word_c = {imm_i[11:0], rs1_i, funct3_i, rd_i, 7'b0000011};
      K_STORE:  word_c = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], 7'b0100011};
      K_BRANCH: word_c = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], 7'b1100011};
      K_JAL:    word_c = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, 7'b1101111};
      K_JALR:   word_c = {imm_i[11:0], rs1_i, 3'b000, rd_i, 7'b1100111};
      K_LUI:    word_c = {imm_i[31:12], rd_i, 7'b0110111};
      K_AUIPC:  word_c = {imm_i[31:12], rd_i, 7'b0010111};
      default:  word_c = NOP_WORD;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [XLEN-1:0] imm_s;
  logic                   fits12_c;
  logic                   err_n;

  assign imm_s    = $signed(imm_i);
  assign fits12_c = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);

  // Immediate legality per instruction format
  always_comb begin
    range_err_c = 1'b0;
    case (kind_i)
      K_IARITH: range_err_c = is_shift_c ? (imm_i > 32'd31) : !fits12_c;
      K_LOAD, K_STORE, K_JALR: range_err_c = !fits12_c;
      K_BRANCH: range_err_c = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm_i[0];
      K_JAL:    range_err_c = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm_i[0];
      K_LUI, K_AUIPC: range_err_c = (imm_i[11:0] != 12'd0);
      default:  range_err_c = 1'b0;
    endcase
  end

  // Sticky error flag
  always_comb begin
    err_n = err_o;
    if (clear_i)                   err_n = 1'b0;
    else if (push_c && range_err_c) err_n = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_o <= 1'b0;
    else       err_o <= err_n;
  end
`else
  assign range_err_c = 1'b0;
  assign err_o       = 1'b0;
`endif

  // FIFO, address counter and word count next state
  always_comb begin
    head_n   = head_q;
    tail_n   = tail_q;
    head_v_n = out_valid_o;
    tail_v_n = tail_v_q;
    addr_n   = addr_q;
    cnt_n    = count_o;
    new_e    = '{instr: word_c, addr: addr_q};
    if (clear_i) begin
      head_n   = '{instr: '0, addr: BASE_ADDR};
      head_v_n = 1'b0;
      tail_v_n = 1'b0;
      addr_n   = BASE_ADDR;
      cnt_n    = '0;
    end else begin
      if (enq_c) begin
        addr_n = addr_q + ADDR_W'(4);
        if (count_o != {CNT_W{1'b1}}) cnt_n = count_o + CNT_W'(1);
      end
      // Push is never accepted while full, so tail promotion and enqueue
      // cannot collide.
      if (pop_c) begin
        if (tail_v_q) begin
          head_n   = tail_q;
          tail_v_n = 1'b0;
        end else if (enq_c) begin
          head_n = new_e;
        end else begin
          head_v_n = 1'b0;
        end
      end else if (enq_c) begin
        if (!out_valid_o) begin
          head_n   = new_e;
          head_v_n = 1'b1;
        end else begin
          tail_n   = new_e;
          tail_v_n = 1'b1;
        end
      end
    end
    ready_n = !(head_v_n && tail_v_n);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q      <= '{instr: '0, addr: BASE_ADDR};
      tail_q      <= '0;
      out_valid_o <= 1'b0;
      tail_v_q    <= 1'b0;
      in_ready_o  <= 1'b1;
      addr_q      <= BASE_ADDR;
      count_o     <= '0;
    end else begin
      head_q      <= head_n;
      tail_q      <= tail_n;
      out_valid_o <= head_v_n;
      tail_v_q    <= tail_v_n;
      in_ready_o  <= ready_n;
      addr_q      <= addr_n;
      count_o     <= cnt_n;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors for instr_encoder with hand-computed
// machine words and addresses. A second instance (ADDR_W=4, BASE_ADDR=0xC)
// covers address wrap.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  kind = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  f3 = '0;
  logic        b5 = 1'b0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] addr;
  logic [15:0] count;
  logic        err;

  logic        w_clear = 1'b0;
  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_out_ready = 1'b0;
  logic [31:0] w_instr;
  logic [3:0]  w_addr;
  logic [15:0] w_count;
  logic        w_err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_addr;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h100)) u_dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .kind_i(kind), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .funct3_i(f3), .funct7b5_i(b5), .imm_i(imm),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .instr_o(instr), .addr_o(addr), .count_o(count), .err_o(err)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) u_wrap (
    .clk_i(clk), .rst_i(rst), .clear_i(w_clear),
    .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
    .kind_i(kind), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .funct3_i(f3), .funct7b5_i(b5), .imm_i(imm),
    .out_valid_o(w_out_valid), .out_ready_i(w_out_ready),
    .instr_o(w_instr), .addr_o(w_addr), .count_o(w_count), .err_o(w_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] fn3, input logic fb5,
                         input logic [31:0] im);
    kind = k; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; b5 = fb5; imm = im;
  endtask

  // Present a request and hold it until accepted (bounded)
  task automatic push(input string tag, input logic [3:0] k, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                      input logic fb5, input logic [31:0] im);
    set_req(k, d, s1, s2, fn3, fb5, im);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_a);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, instr, exp_instr);
    chk({tag, "_addr"}, addr, exp_a);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic enc(input string tag, input logic [3:0] k, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                     input logic fb5, input logic [31:0] im, input logic [31:0] exp_instr);
    push(tag, k, d, s1, s2, fn3, fb5, im);
    pop_chk(tag, exp_instr, exp_addr);
    exp_addr += 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] wrap_exp [3];
    wrap_exp = '{4'hC, 4'h0, 4'h4};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr",     instr,          32'd0);
    chk("rst_addr",      addr,           32'h100);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_err",       32'(err),       32'd0);
    rst = 1'b0;
    exp_addr = 32'h100;

    enc("add",   4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0,          32'h002081B3);
    enc("sub",   4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0,          32'h402081B3);
    chk("count2", 32'(count), 32'd2);
    enc("addi",  4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5,          32'h00500093);
    enc("beq",   4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFFC,   32'hFE208EE3);
    enc("jal",   4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8,          32'h008000EF);
    enc("lui",   4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000,   32'h123452B7);
    enc("nop12", 4'd12, 5'd7, 5'd7, 5'd7, 3'd7, 1'b1, 32'hFFFFFFFF,  32'h00000013);
    enc("sw",    4'd3, 5'd0, 5'd1, 5'd2, 3'd2, 1'b0, 32'd8,          32'h0020A423);
    enc("srai",  4'd1, 5'd1, 5'd1, 5'd0, 3'd5, 1'b1, 32'd3,          32'h4030D093);
    enc("jalr",  4'd6, 5'd1, 5'd2, 5'd0, 3'd3, 1'b0, 32'd0,          32'h000100E7);
    chk("count10", 32'(count), 32'd10);

    // Backpressure: fill the FIFO, hold a third request, then drain
    out_ready = 1'b0;
    push("bp_a", 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1);
    push("bp_b", 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2);
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_instr", instr, 32'h00100093);
    chk("bp_hold_addr",  addr,  exp_addr);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_b_instr", instr, 32'h00200093);
    chk("bp_b_addr",  addr,  exp_addr + 32'd4);
    chk("bp_b_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_c_instr", instr, 32'h00300093);
    chk("bp_c_addr",  addr,  exp_addr + 32'd8);
    chk("bp_c_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_empty", 32'(out_valid), 32'd0);
    exp_addr += 32'd12;
    chk("count13", 32'(count), 32'd13);

    // Out-of-range addi immediate
    push("range", 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
`ifdef ENCODER_RANGE_CHECK_EN
    chk("range_no_valid", 32'(out_valid), 32'd0);
    chk("range_err",      32'(err),       32'd1);
    chk("range_count",    32'(count),     32'd13);
    enc("after_err", 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7, 32'h00700093);
    chk("err_sticky", 32'(err), 32'd1);
`else
    pop_chk("range_trunc", 32'h80000093, exp_addr);
    exp_addr += 32'd4;
    chk("range_err_tied", 32'(err), 32'd0);
`endif

    // Clear beats a same-cycle request
    set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd9);
    in_valid = 1'b1;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_err",   32'(err),       32'd0);
    chk("clr_count", 32'(count),     32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_addr",  addr,           32'h100);
    exp_addr = 32'h100;
    enc("post_clr", 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 32'h00500093);

    // Asynchronous reset with two words buffered
    push("rs_a", 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1);
    push("rs_b", 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2);
    chk("rs_full", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("rs_async_valid", 32'(out_valid), 32'd0);
    chk("rs_async_count", 32'(count),     32'd0);
    chk("rs_async_ready", 32'(in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_addr = 32'h100;
    enc("post_rst", 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 32'h002081B3);

    // Address wrap on the 4-bit instance, streaming one word per cycle
    set_req(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    w_in_valid  = 1'b1;
    w_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("wrap_addr%0d", i), 32'(w_addr), 32'(wrap_exp[i]));
      chk($sformatf("wrap_valid%0d", i), 32'(w_out_valid), 32'd1);
    end
    w_in_valid = 1'b0;
    chk("wrap_instr", w_instr, 32'h00500093);
    @(posedge clk); #1;
    w_out_ready = 1'b0;
    chk("wrap_empty", 32'(w_out_valid), 32'd0);
    chk("wrap_count", 32'(w_count),     32'd3);
    chk("wrap_ready", 32'(w_in_ready),  32'd1);
    chk("wrap_err",   32'(w_err),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- RV32I instruction encoder: the inverse of the core's control/immediate decode path.
- Accepts decoded fields (instruction kind, registers, funct bits, immediate) over a valid/ready handshake and packs them into 32-bit machine words.
- Words are buffered in a 2-entry FIFO and emitted with an incrementing word address.
- Used by the bench and the boot loader to write programs into instruction memory.

## Interface
- ADDR_W, 32: width of address counter and addr_o
- BASE_ADDR, 0: address of first emitted word; value after reset/clear
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous flush: empties FIFO, address to BASE_ADDR, count_o and err_o to 0
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i && in_ready_o
- kind_i  in  4  0 R, 1 I-arith, 2 load, 3 store, 4 branch, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- funct3_i  in  3  funct3 (ignored for JAL/JALR/LUI/AUIPC)
- funct7b5_i  in  1  instr bit 30 (SUB/SRA); used for R and I-arith shifts only
- imm_i  in  32  signed byte immediate; U-type uses imm_i[31:12] placed directly
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  consumer takes head when out_valid_o && out_ready_i
- instr_o  out  32  encoded word at FIFO head
- addr_o  out  ADDR_W  address of word at FIFO head
- count_o  out  16  words enqueued since reset/clear, saturating at 0xFFFF
- err_o  out  1  sticky range-error flag

## Operation
- Encode is combinational from request fields; result and address are written to the FIFO on acceptance.
- Opcodes:
  - R 0110011: funct7 = {0, funct7b5_i, 00000}
  - I-arith 0010011: for funct3 001/101, imm[11:0] = {0, funct7b5_i, 00000, imm_i[4:0]}; otherwise imm_i[11:0]
  - load 0000011
  - store 0100011
  - branch 1100011, imm_i[12:1]
  - JAL 1101111, imm_i[20:1]
  - JALR 1100111, funct3 = 000
  - LUI 0110111
  - AUIPC 0010111
- kind_i > 8 encodes as NOP 32'h00000013.
- Address counter:
  - starts at BASE_ADDR;
  - +4 per enqueued word;
  - wraps modulo 2^ADDR_W;
  - each FIFO entry stores its own address.
- FIFO: 2 entries.
  - in_ready_o = !full; no bypass when full, even if out_ready_i is high in the same cycle.
  - Simultaneous push and pop with 1 entry: occupancy stays 1; the new word becomes head the next cycle.
  - Pop on empty is ignored.
- clear_i has priority over a same-cycle push or pop; the request is not accepted.
- Reset values:
  - in_ready_o 1
  - out_valid_o 0
  - instr_o 0
  - addr_o BASE_ADDR
  - count_o 0
  - err_o 0
  - FIFO empty
- Reset mid-operation discards all buffered words immediately; no partial handshake completes.

## Timing
- Latency: accept in cycle N, out_valid_o high in N+1 if the FIFO was empty.
- Throughput: one word per cycle with out_ready_i held high.
- in_ready_o, out_valid_o, instr_o and addr_o are registered; no combinational path from out_ready_i to in_ready_o.
- instr_o and addr_o are stable while out_valid_o && !out_ready_i.

## Configuration
- ENCODER_RANGE_CHECK_EN
- Defined:
  - An accepted request is range-checked. Each of the following is a violation:
    - I/S/JALR/load immediate outside [-2048, 2047]
    - branch immediate outside [-4096, 4094] or odd
    - JAL immediate outside [-2^20, 2^20-2] or odd
    - shift amount imm_i > 31
    - LUI/AUIPC imm_i[11:0] ≠ 0
  - On a violation the request is consumed but not enqueued; address and count_o do not change; err_o sets the next cycle and stays set until clear_i or reset.
- Undefined:
  - Out-of-range fields are silently truncated to their encoded bits and enqueued.
  - err_o is tied to 0.

## Test plan
- R-type, BASE_ADDR 0x100:
  - add x3,x1,x2 (kind 0, f3 0, b5 0) → instr_o 0x002081B3, addr_o 0x100
  - then sub → 0x402081B3, addr_o 0x104
- Immediates:
  - addi x1,x0,5 → 0x00500093
  - beq x1,x2,-4 → 0xFE208EE3
  - jal x1,8 → 0x008000EF
  - lui x5,0x12345000 → 0x123452B7
  - kind 12 → 0x00000013
- Backpressure: out_ready_i=0, push 3 requests → in_ready_o low after 2 accepts; raise out_ready_i → words pop in order, third accepted, addresses consecutive.
- Wrap: ADDR_W=4, BASE_ADDR=0xC → emitted addresses 0xC, 0x0, 0x4.
- Range check, macro defined: addi imm 2048 → no out_valid_o, err_o=1 next cycle, next valid word keeps the prior address; clear_i → err_o 0, addr BASE_ADDR.
- Reset: assert rst_i with 2 words buffered → out_valid_o 0 and count_o 0 asynchronously; first push after release → addr_o BASE_ADDR.
